// File: rtl/multi_alarm_clock.sv
// 24-hour time-of-day counter with NUM_ALARMS programmable alarm slots, snooze,
// ring auto-timeout and a 12-hour display view.
module multi_alarm_clock #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int NUM_ALARMS    = 4,
    parameter int IDX_W         = 2,
    parameter int SNOOZE_MIN    = 5,
    parameter int RING_SECONDS  = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_time,
    input  logic [4:0]            hr_in,
    input  logic [5:0]            min_in,
    input  logic [5:0]            sec_in,
    input  logic                  set_alarm,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic [4:0]            alarm_hr_in,
    input  logic [5:0]            alarm_min_in,
    input  logic                  alarm_en_in,
    input  logic                  alarm_clear,
    input  logic                  snooze,
    input  logic                  mode_12h,
    output logic [4:0]            hr,
    output logic [5:0]            min,
    output logic [5:0]            sec,
    output logic [4:0]            hr_disp,
    output logic                  pm,
    output logic                  tick_1hz,
    output logic                  alarm_active,
    output logic [NUM_ALARMS-1:0] alarm_src
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    logic [PW-1:0]         presc_q, presc_d;
    logic [4:0]            hr_q, hr_d, adv_hr;
    logic [5:0]            min_q, min_d, adv_min;
    logic [5:0]            sec_q, sec_d, adv_sec;
    state_t                state_q, state_d;
    logic [NUM_ALARMS-1:0] src_q, src_d, match_vec;
    logic [7:0]            cnt_q, cnt_d;
    logic [4:0]            thr_q, thr_d, snz_hr;
    logic [5:0]            tmin_q, tmin_d, snz_min;
    logic [6:0]            snz_sum;
    logic                  tick, set_ok, tick_adv, alarm_wr_ok, snz_hit;
    logic [4:0]            hr12;

    assign tick        = (presc_q == PW'(TICKS_PER_SEC - 1));
    assign set_ok      = set_time && (hr_in <= 5'd23) && (min_in <= 6'd59) && (sec_in <= 6'd59);
    assign tick_adv    = tick && !set_ok;
    assign alarm_wr_ok = set_alarm && (int'(alarm_idx) < NUM_ALARMS) &&
                         (alarm_hr_in <= 5'd23) && (alarm_min_in <= 6'd59);

    // Time one second ahead of the current value, with full carry chain.
    always_comb begin
        adv_sec = sec_q + 6'd1;
        adv_min = min_q;
        adv_hr  = hr_q;
        if (sec_q == 6'd59) begin
            adv_sec = '0;
            if (min_q == 6'd59) begin
                adv_min = '0;
                adv_hr  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
                adv_min = min_q + 6'd1;
            end
        end
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        hr_d    = tick ? adv_hr  : hr_q;
        min_d   = tick ? adv_min : min_q;
        sec_d   = tick ? adv_sec : sec_q;
        if (set_ok) begin
            presc_d = '0;
            hr_d    = hr_in;
            min_d   = min_in;
            sec_d   = sec_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
        end
    end

    // Matches only fire on a tick-driven advance onto HH:MM:00; loads never match.
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
        logic [4:0] slot_hr_q;
        logic [5:0] slot_min_q;
        logic       slot_en_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_hr_q  <= '0;
                slot_min_q <= '0;
                slot_en_q  <= 1'b0;
            end else if (alarm_wr_ok && (alarm_idx == IDX_W'(gi))) begin
                slot_hr_q  <= alarm_hr_in;
                slot_min_q <= alarm_min_in;
                slot_en_q  <= alarm_en_in;
            end
        end

        assign match_vec[gi] = tick_adv && (adv_sec == 6'd0) && slot_en_q &&
                               (slot_hr_q == adv_hr) && (slot_min_q == adv_min);
    end

    assign snz_sum = {1'b0, min_q} + 7'(SNOOZE_MIN);
    always_comb begin
        snz_min = snz_sum[5:0];
        snz_hr  = hr_q;
        if (snz_sum >= 7'd60) begin
            snz_min = 6'(snz_sum - 7'd60);
            snz_hr  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end
    end

    assign snz_hit = tick_adv && (adv_sec == 6'd0) && (adv_hr == thr_q) && (adv_min == tmin_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        tmin_d  = tmin_q;
        case (state_q)
            IDLE: begin
                if (|match_vec) begin
                    state_d = RINGING;
                    src_d   = match_vec;
                    cnt_d   = '0;
                end
            end
            RINGING: begin
                if (alarm_clear) begin
                    state_d = IDLE;
                    src_d   = '0;
                end else if (snooze) begin
                    state_d = SNOOZED;
                    thr_d   = snz_hr;
                    tmin_d  = snz_min;
                end else if (|match_vec) begin
                    src_d = src_q | match_vec;
                    cnt_d = '0;
                end else if (tick_adv) begin
                    if (cnt_q == 8'(RING_SECONDS - 1)) begin
                        state_d = IDLE;
                        src_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            SNOOZED: begin
                if (alarm_clear) begin
                    state_d = IDLE;
                    src_d   = '0;
                end else if (snz_hit || (|match_vec)) begin
                    state_d = RINGING;
                    src_d   = src_q | match_vec;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= '0;
            tmin_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            tmin_q  <= tmin_d;
        end
    end

    always_comb begin
        hr12 = hr_q;
        if (hr_q == 5'd0)
            hr12 = 5'd12;
        else if (hr_q > 5'd12)
            hr12 = hr_q - 5'd12;
    end

    assign hr           = hr_q;
    assign min          = min_q;
    assign sec          = sec_q;
    assign hr_disp      = mode_12h ? hr12 : hr_q;
    assign pm           = (hr_q >= 5'd12);
    assign tick_1hz     = tick;
    assign alarm_active = (state_q == RINGING);
    assign alarm_src    = src_q;
endmodule
